// File: rtl/euler_update_stage_if.sv
// rtl/euler_update_stage_if.sv - control, pipeline handshake and memory bus of the Euler update stage
interface euler_update_stage_if #(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int MAX_DIM   = 6
);
    logic                 start;
    logic [MAX_DIM-1:0]   shape_0;
    logic [DATA_SIZE-1:0] step_h;
    logic                 data_ready;
    logic [DATA_SIZE-1:0] out_acc;
    logic                 acc_overflow;
    logic [ADD_SIZE-1:0]  x_rd_addr;
    logic [DATA_SIZE-1:0] x_rd_data;
    logic                 xn_wr_en;
    logic [ADD_SIZE-1:0]  xn_wr_addr;
    logic [DATA_SIZE-1:0] xn_wr_data;
    logic                 return_default_state;
    logic                 FINAL_DONE;
    logic                 overflow;
    logic                 busy;

    modport slave (
        input  start, shape_0, step_h, data_ready, out_acc, acc_overflow, x_rd_data,
        output x_rd_addr, xn_wr_en, xn_wr_addr, xn_wr_data, return_default_state,
               FINAL_DONE, overflow, busy
    );

    modport master (
        output start, shape_0, step_h, data_ready, out_acc, acc_overflow, x_rd_data,
        input  x_rd_addr, xn_wr_en, xn_wr_addr, xn_wr_data, return_default_state,
               FINAL_DONE, overflow, busy
    );
endinterface

// File: rtl/euler_update_stage.sv
// rtl/euler_update_stage.sv - computes x_next[i] = x[i] + h*acc[i] per finished row, saturating
module euler_update_stage #(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int MAX_DIM   = 6,
    parameter int FRAC_BITS = 8,
    parameter int X_BASE    = 0,
    parameter int XN_BASE   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    euler_update_stage_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_ACC = 3'd1;
    localparam logic [2:0] S_MUL      = 3'd2;
    localparam logic [2:0] S_ADD      = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int PW = 2 * DATA_SIZE;
    localparam logic [MAX_DIM-1:0] ROW_ONE = MAX_DIM'(1);
    localparam logic signed [PW:0] SAT_MAX = $signed({{(DATA_SIZE + 2){1'b0}}, {(DATA_SIZE - 1){1'b1}}});
    localparam logic signed [PW:0] SAT_MIN = $signed({{(DATA_SIZE + 2){1'b1}}, {(DATA_SIZE - 1){1'b0}}});
    localparam logic [DATA_SIZE-1:0] POS_FULL = {1'b0, {(DATA_SIZE - 1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] NEG_FULL = {1'b1, {(DATA_SIZE - 1){1'b0}}};

    logic [2:0]           state_q, state_d;
    logic [MAX_DIM-1:0]   row_count_q, row_count_d;
    logic [DATA_SIZE-1:0] h_reg_q, h_reg_d;
    logic [DATA_SIZE-1:0] acc_reg_q, acc_reg_d;
    logic [DATA_SIZE-1:0] x_reg_q, x_reg_d;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic [PW-1:0]        prod_reg_q, prod_reg_d;
    logic                 overflow_q, overflow_d;

    logic signed [PW-1:0] prod_full;
    logic signed [PW-1:0] prod_shift;
    logic signed [PW:0]   sum_full;
    logic                 last_row;

    // Operands widened first so the product is exact; >>> floors toward -inf
    assign prod_full  = $signed({{DATA_SIZE{h_reg_q[DATA_SIZE-1]}}, h_reg_q})
                      * $signed({{DATA_SIZE{acc_reg_q[DATA_SIZE-1]}}, acc_reg_q});
    assign prod_shift = prod_full >>> FRAC_BITS;
    assign sum_full   = $signed({{(DATA_SIZE + 1){x_reg_q[DATA_SIZE-1]}}, x_reg_q})
                      + $signed({prod_reg_q[PW-1], prod_reg_q});
    assign last_row   = (row_count_q + ROW_ONE) == bus.shape_0;

    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        h_reg_d     = h_reg_q;
        acc_reg_d   = acc_reg_q;
        x_reg_d     = x_reg_q;
        wr_data_d   = wr_data_q;
        prod_reg_d  = prod_reg_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    h_reg_d     = bus.step_h;
                    row_count_d = '0;
                    overflow_d  = 1'b0;
                    state_d     = (bus.shape_0 == '0) ? S_DONE : S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (bus.data_ready) begin
                    acc_reg_d  = bus.out_acc;
                    overflow_d = overflow_q | bus.acc_overflow;
                    state_d    = S_MUL;
                end
            end
            S_MUL: begin
                prod_reg_d = prod_shift;
                x_reg_d    = bus.x_rd_data;
                state_d    = S_ADD;
            end
            S_ADD: begin
                if (sum_full > SAT_MAX) begin
                    wr_data_d  = POS_FULL;
                    overflow_d = 1'b1;
                end else if (sum_full < SAT_MIN) begin
                    wr_data_d  = NEG_FULL;
                    overflow_d = 1'b1;
                end else begin
                    wr_data_d  = sum_full[DATA_SIZE-1:0];
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_count_d = row_count_q + ROW_ONE;
                    state_d     = S_WAIT_ACC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_count_q <= '0;
            h_reg_q     <= '0;
            acc_reg_q   <= '0;
            x_reg_q     <= '0;
            wr_data_q   <= '0;
            prod_reg_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            h_reg_q     <= h_reg_d;
            acc_reg_q   <= acc_reg_d;
            x_reg_q     <= x_reg_d;
            wr_data_q   <= wr_data_d;
            prod_reg_q  <= prod_reg_d;
            overflow_q  <= overflow_d;
        end
    end

    // Address is only driven during the write so the bus idles at zero
    assign bus.x_rd_addr            = ADD_SIZE'(X_BASE) + ADD_SIZE'(row_count_q);
    assign bus.xn_wr_en             = (state_q == S_WRITE);
    assign bus.xn_wr_addr           = (state_q == S_WRITE) ? ADD_SIZE'(XN_BASE) + ADD_SIZE'(row_count_q) : '0;
    assign bus.xn_wr_data           = wr_data_q;
    assign bus.return_default_state = (state_q == S_WRITE);
    assign bus.FINAL_DONE           = (state_q == S_DONE);
    assign bus.overflow             = overflow_q;
    assign bus.busy                 = (state_q != S_IDLE);
endmodule
